// File: rtl/argon_pkg.sv
// Shared definitions for the argon operand stage.
//   - default widths for opcode, data and register index
//   - ALU opcode encodings (passed through untouched by the operand stage)
//   - state encoding of the operand stage output buffer
package argon_pkg;

  localparam int DEF_OPWIDTH      = 3;
  localparam int DEF_DATAWIDTH    = 16;
  localparam int DEF_REGADDRWIDTH = 3;

  localparam logic [DEF_OPWIDTH-1:0] OP_ADD = 3'd0;
  localparam logic [DEF_OPWIDTH-1:0] OP_SUB = 3'd1;
  localparam logic [DEF_OPWIDTH-1:0] OP_AND = 3'd2;
  localparam logic [DEF_OPWIDTH-1:0] OP_OR  = 3'd3;
  localparam logic [DEF_OPWIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [DEF_OPWIDTH-1:0] OP_SLL = 3'd5;
  localparam logic [DEF_OPWIDTH-1:0] OP_SRL = 3'd6;
  localparam logic [DEF_OPWIDTH-1:0] OP_SLT = 3'd7;

  // EMPTY: nothing held; FULL: OUT holds an entry; SKID: OUT and SKID both hold.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/argon_regfile.sv
// Architectural register file for the argon operand stage.
//   clk_i, rst_ni            : clock, async active-low reset (clears all registers)
//   rd_addr_a_i/rd_data_a_o  : combinational read port A
//   rd_addr_b_i/rd_data_b_o  : combinational read port B
//   wb_valid_i/wb_addr_i/wb_data_i : synchronous write port
// Register 0 always reads as zero and ignores writes. A read that hits the
// register being written this cycle returns the incoming write data.
module argon_regfile
  import argon_pkg::*;
#(
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int REGADDRWIDTH = DEF_REGADDRWIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [REGADDRWIDTH-1:0] rd_addr_a_i,
  output logic [DATAWIDTH-1:0]    rd_data_a_o,
  input  logic [REGADDRWIDTH-1:0] rd_addr_b_i,
  output logic [DATAWIDTH-1:0]    rd_data_b_o,
  input  logic                    wb_valid_i,
  input  logic [REGADDRWIDTH-1:0] wb_addr_i,
  input  logic [DATAWIDTH-1:0]    wb_data_i
);

  localparam int NREG = 2 ** REGADDRWIDTH;

  logic [DATAWIDTH-1:0] regs_q [NREG];
  logic                 wb_live;

  // Writes to register 0 are dropped, so it can never be a bypass source.
  assign wb_live = wb_valid_i && (wb_addr_i != '0);

  // NOTE: this array is a handful of flops, not a RAM macro, so it can take the
  // async clear; a RAM-backed register file could not be reset this way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_live) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rd_data_a_o = (rd_addr_a_i == '0)                   ? '0        :
                       (wb_live && wb_addr_i == rd_addr_a_i) ? wb_data_i :
                                                               regs_q[rd_addr_a_i];
  assign rd_data_b_o = (rd_addr_b_i == '0)                   ? '0        :
                       (wb_live && wb_addr_i == rd_addr_b_i) ? wb_data_i :
                                                               regs_q[rd_addr_b_i];

endmodule

// File: rtl/argon_operand_stage.sv
// Issue / operand-fetch stage feeding the ALU.
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_valid/o_ready + i_op, i_rd, i_rs1, i_rs2, i_useImm, i_imm : upstream instruction
//   o_valid/i_ready + o_op, o_wordA, o_wordB, o_rd              : registered ALU side
//   i_wbValid, i_wbRd, i_wbData    : writeback into the register file
// Outputs come from a registered OUT slot backed by a one-entry SKID slot, so
// o_ready depends only on local state. Held entries snoop writeback so their
// operands never go stale while the ALU is stalled.
module argon_operand_stage
  import argon_pkg::*;
#(
  parameter int OPWIDTH      = DEF_OPWIDTH,
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int REGADDRWIDTH = DEF_REGADDRWIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [OPWIDTH-1:0]      i_op,
  input  logic [REGADDRWIDTH-1:0] i_rd,
  input  logic [REGADDRWIDTH-1:0] i_rs1,
  input  logic [REGADDRWIDTH-1:0] i_rs2,
  input  logic                    i_useImm,
  input  logic [DATAWIDTH-1:0]    i_imm,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [OPWIDTH-1:0]      o_op,
  output logic [DATAWIDTH-1:0]    o_wordA,
  output logic [DATAWIDTH-1:0]    o_wordB,
  output logic [REGADDRWIDTH-1:0] o_rd,
  input  logic                    i_wbValid,
  input  logic [REGADDRWIDTH-1:0] i_wbRd,
  input  logic [DATAWIDTH-1:0]    i_wbData
);

  typedef struct packed {
    logic [OPWIDTH-1:0]      op;
    logic [REGADDRWIDTH-1:0] rd;
    logic [REGADDRWIDTH-1:0] rs1;
    logic [REGADDRWIDTH-1:0] rs2;
    logic                    use_imm;
    logic [DATAWIDTH-1:0]    word_a;
    logic [DATAWIDTH-1:0]    word_b;
  } entry_t;

  stage_state_e         state_q, state_d;
  entry_t               out_q, out_d, skid_q, skid_d, new_entry;
  logic                 accept, fire;
  logic [DATAWIDTH-1:0] rdata_a, rdata_b;

  argon_regfile #(
    .DATAWIDTH   (DATAWIDTH),
    .REGADDRWIDTH(REGADDRWIDTH)
  ) u_regfile (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .rd_addr_a_i(i_rs1),
    .rd_data_a_o(rdata_a),
    .rd_addr_b_i(i_rs2),
    .rd_data_b_o(rdata_b),
    .wb_valid_i (i_wbValid),
    .wb_addr_i  (i_wbRd),
    .wb_data_i  (i_wbData)
  );

  // Refresh a held entry's operands from this cycle's writeback. Immediate
  // operands are not register-sourced and are left alone.
  function automatic entry_t snoop(input entry_t                    e,
                                   input logic                      wb_valid,
                                   input logic [REGADDRWIDTH-1:0]   wb_rd,
                                   input logic [DATAWIDTH-1:0]      wb_data);
    entry_t r;
    r = e;
    if (wb_valid && wb_rd != '0) begin
      if (e.rs1 == wb_rd)                r.word_a = wb_data;
      if (!e.use_imm && e.rs2 == wb_rd)  r.word_b = wb_data;
    end
    return r;
  endfunction

  assign o_ready = (state_q != ST_SKID);
  assign o_valid = (state_q != ST_EMPTY);
  assign accept  = i_valid && o_ready;
  assign fire    = o_valid && i_ready;

  // Register reads already include the writeback bypass, so a fresh entry
  // needs no snoop of its own.
  always_comb begin
    new_entry.op      = i_op;
    new_entry.rd      = i_rd;
    new_entry.rs1     = i_rs1;
    new_entry.rs2     = i_rs2;
    new_entry.use_imm = i_useImm;
    new_entry.word_a  = rdata_a;
    new_entry.word_b  = i_useImm ? i_imm : rdata_b;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    state_d = state_q;
    out_d   = snoop(out_q,  i_wbValid, i_wbRd, i_wbData);
    skid_d  = snoop(skid_q, i_wbValid, i_wbRd, i_wbData);
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && fire) begin
          out_d = new_entry;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_SKID;
        end
      end
      ST_SKID: begin
        // skid_d already carries this cycle's snoop, so the moving entry
        // arrives in OUT with up-to-date operands.
        if (fire) begin
          out_d   = skid_d;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments; the combinational
  // blocks above use blocking ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign o_op    = out_q.op;
  assign o_wordA = out_q.word_a;
  assign o_wordB = out_q.word_b;
  assign o_rd    = out_q.rd;

endmodule

// File: tb/tb_argon_operand_stage.sv
module tb_argon_operand_stage;
  import argon_pkg::*;

  localparam int OW = 3;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          i_clk, i_rst_n;
  logic          i_valid, o_ready, i_useImm, o_valid, i_ready, i_wbValid;
  logic [OW-1:0] i_op, o_op;
  logic [AW-1:0] i_rd, i_rs1, i_rs2, o_rd, i_wbRd;
  logic [DW-1:0] i_imm, o_wordA, o_wordB, i_wbData;

  int n_checks = 0;
  int n_fail   = 0;

  argon_operand_stage #(.OPWIDTH(OW), .DATAWIDTH(DW), .REGADDRWIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_useImm(i_useImm), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_op(o_op), .o_wordA(o_wordA), .o_wordB(o_wordB), .o_rd(o_rd),
    .i_wbValid(i_wbValid), .i_wbRd(i_wbRd), .i_wbData(i_wbData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic ui, input logic [DW-1:0] imm, input logic rdy,
                       input logic wbv, input logic [AW-1:0] wbrd, input logic [DW-1:0] wbd);
    i_valid = v;  i_op = op;  i_rd = rd;  i_rs1 = rs1;  i_rs2 = rs2;
    i_useImm = ui;  i_imm = imm;  i_ready = rdy;
    i_wbValid = wbv;  i_wbRd = wbrd;  i_wbData = wbd;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic v; logic [OW-1:0] op; logic [AW-1:0] rd, rs1, rs2; logic ui; logic [DW-1:0] imm;
    logic rdy; logic wbv; logic [AW-1:0] wbrd; logic [DW-1:0] wbd;
    logic ev, er; logic [OW-1:0] eop; logic [DW-1:0] ea, eb; logic [AW-1:0] erd;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic ui,
                         input logic [DW-1:0] imm, input logic rdy, input logic wbv,
                         input logic [AW-1:0] wbrd, input logic [DW-1:0] wbd,
                         input logic ev, input logic er, input logic [OW-1:0] eop,
                         input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [AW-1:0] erd);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.ui = ui; t.imm = imm;
    t.rdy = rdy; t.wbv = wbv; t.wbrd = wbrd; t.wbd = wbd;
    t.ev = ev; t.er = er; t.eop = eop; t.ea = ea; t.eb = eb; t.erd = erd;
    vecs.push_back(t);
  endtask

  // ---------------- behavioural reference model ----------------
  // The stage behaves as a two-deep FIFO of fetched instructions whose operands
  // track writeback; the head of the FIFO is what the ALU sees.
  typedef struct {
    logic [OW-1:0] op; logic [AW-1:0] rd, rs1, rs2; logic ui; logic [DW-1:0] a, b;
  } mentry_t;
  mentry_t       mq[$];
  logic [DW-1:0] mregs [8];

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] idx, input logic wbv,
                                          input logic [AW-1:0] wbrd, input logic [DW-1:0] wbd);
    if (idx == 0)               return '0;
    if (wbv && wbrd == idx)     return wbd;
    return mregs[idx];
  endfunction

  task automatic model_cycle(input string tag);
    bit acc, fir;
    mentry_t ne;
    logic wbv; logic [AW-1:0] wbrd; logic [DW-1:0] wbd;
    wbv = i_wbValid; wbrd = i_wbRd; wbd = i_wbData;
    acc = i_valid && (mq.size() < 2);
    fir = (mq.size() > 0) && i_ready;
    ne.op = i_op; ne.rd = i_rd; ne.rs1 = i_rs1; ne.rs2 = i_rs2; ne.ui = i_useImm;
    ne.a = mread(i_rs1, wbv, wbrd, wbd);
    ne.b = i_useImm ? i_imm : mread(i_rs2, wbv, wbrd, wbd);
    step();
    if (wbv && wbrd != 0) begin
      foreach (mq[k]) begin
        if (mq[k].rs1 == wbrd)             mq[k].a = wbd;
        if (!mq[k].ui && mq[k].rs2 == wbrd) mq[k].b = wbd;
      end
      mregs[wbrd] = wbd;
    end
    if (fir) void'(mq.pop_front());
    if (acc) mq.push_back(ne);
    check({tag, "_ready"}, 64'(o_ready), 64'(mq.size() < 2));
    check({tag, "_valid"}, 64'(o_valid), 64'(mq.size() > 0));
    if (mq.size() > 0)
      check({tag, "_data"}, 64'({o_op, o_wordA, o_wordB, o_rd}),
            64'({mq[0].op, mq[0].a, mq[0].b, mq[0].rd}));
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_outs",  64'({o_op, o_wordA, o_wordB, o_rd}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    //       v op      rd rs1 rs2 ui imm       rdy wbv wbrd wbd       ev er eop     ea         eb         erd
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  1,  3,   16'h1234, 0, 1, 0,      0,         0,         0);
    add_vec(1, OP_ADD, 5, 3,  0,  0, 0,        1,  0,  0,   0,        1, 1, OP_ADD, 16'h1234,  0,         5);
    add_vec(1, OP_SUB, 1, 2,  3,  0, 0,        1,  1,  2,   16'hBEEF, 1, 1, OP_SUB, 16'hBEEF,  16'h1234,  1);
    add_vec(1, OP_AND, 2, 0,  2,  0, 0,        1,  1,  0,   16'h5555, 1, 1, OP_AND, 0,         16'hBEEF,  2);
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  0,  0,   0,        0, 1, 0,      0,         0,         0);
    add_vec(1, OP_OR,  6, 3,  2,  0, 0,        0,  0,  0,   0,        1, 1, OP_OR,  16'h1234,  16'hBEEF,  6);
    add_vec(1, OP_XOR, 7, 2,  0,  1, 16'h00F0, 0,  0,  0,   0,        1, 0, OP_OR,  16'h1234,  16'hBEEF,  6);
    add_vec(1, OP_SLL, 4, 1,  1,  0, 0,        0,  0,  0,   0,        1, 0, OP_OR,  16'h1234,  16'hBEEF,  6);
    add_vec(1, OP_SLL, 4, 1,  1,  0, 0,        1,  0,  0,   0,        1, 1, OP_XOR, 16'hBEEF,  16'h00F0,  7);
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  0,  0,   0,        0, 1, 0,      0,         0,         0);
    add_vec(1, OP_SRL, 3, 4,  4,  1, 16'h0007, 0,  0,  0,   0,        1, 1, OP_SRL, 0,         16'h0007,  3);
    add_vec(0, 0,      0, 0,  0,  0, 0,        0,  1,  4,   16'h00AA, 1, 1, OP_SRL, 16'h00AA,  16'h0007,  3);
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  0,  0,   0,        0, 1, 0,      0,         0,         0);
    add_vec(1, OP_AND, 1, 1,  0,  0, 0,        0,  0,  0,   0,        1, 1, OP_AND, 0,         0,         1);
    add_vec(1, OP_SLT, 2, 0,  1,  0, 0,        0,  1,  1,   16'h0101, 1, 0, OP_AND, 16'h0101,  0,         1);
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  1,  1,   16'h0202, 1, 1, OP_SLT, 0,         16'h0202,  2);
    add_vec(0, 0,      0, 0,  0,  0, 0,        1,  0,  0,   0,        0, 1, 0,      0,         0,         0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].ui,
            vecs[i].imm, vecs[i].rdy, vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd);
      step();
      check($sformatf("row%0d_ready", i), 64'(o_ready), 64'(vecs[i].er));
      check($sformatf("row%0d_valid", i), 64'(o_valid), 64'(vecs[i].ev));
      if (vecs[i].ev)
        check($sformatf("row%0d_data", i), 64'({o_op, o_wordA, o_wordB, o_rd}),
              64'({vecs[i].eop, vecs[i].ea, vecs[i].eb, vecs[i].erd}));
    end

    // Asynchronous reset while both slots are occupied.
    drive(1, OP_ADD, 1, 3, 4, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, OP_SUB, 2, 1, 2, 0, 0, 0, 0, 0, 0);
    step();
    check("skid_ready_low", 64'(o_ready), 64'd0);
    check("skid_valid",     64'(o_valid), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'd0);
    check("async_rst_ready", 64'(o_ready), 64'd1);
    check("async_rst_outs",  64'({o_op, o_wordA, o_wordB, o_rd}), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1, OP_OR, 5, 3, 4, 0, 0, 1, 0, 0, 0);
    step();
    check("post_rst_regs", 64'({o_valid, o_wordA, o_wordB, o_rd}), 64'({1'b1, 16'h0, 16'h0, 3'd5}));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    check("post_rst_drain", 64'(o_valid), 64'd0);

    // Model-checked phases start from the post-reset state.
    for (int r = 0; r < 8; r++) mregs[r] = '0;
    mq.delete();

    for (int s = 0; s < 8; s++) begin
      drive(1, OW'(s), AW'(s), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), DW'($urandom), 1, 1, AW'(s), DW'($urandom));
      model_cycle($sformatf("stream%0d", s));
    end

    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), OW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            DW'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), DW'($urandom));
      model_cycle($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/argon_operand_stage.md
Name: argon_operand_stage

Overview:
- Issue/operand-fetch stage directly upstream of the ALU. Holds the architectural register file.
- Accepts decoded instructions over a valid/ready handshake and reads source operands, bypassing same-cycle writeback.
- Selects an immediate for operand B and presents op/wordA/wordB/rd to the ALU through a registered output with a one-entry skid buffer.
- Writeback from the downstream stage enters through a dedicated write port.

Parameters:
- OPWIDTH, 3, ALU opcode width.
- DATAWIDTH, 16, register and operand width.
- REGADDRWIDTH, 3, register index width; register count is 2**REGADDRWIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_op  in  OPWIDTH  ALU opcode, passed through.
- i_rd  in  REGADDRWIDTH  destination register, passed through.
- i_rs1  in  REGADDRWIDTH  source register for operand A.
- i_rs2  in  REGADDRWIDTH  source register for operand B.
- i_useImm  in  1  1: operand B = i_imm; 0: operand B = R[i_rs2].
- i_imm  in  DATAWIDTH  immediate value.
- o_valid  out  1  ALU-side instruction valid.
- i_ready  in  1  ALU side accepts.
- o_op  out  OPWIDTH  opcode to ALU.
- o_wordA  out  DATAWIDTH  operand A to ALU.
- o_wordB  out  DATAWIDTH  operand B to ALU.
- o_rd  out  REGADDRWIDTH  destination register, forwarded for writeback.
- i_wbValid  in  1  writeback enable.
- i_wbRd  in  REGADDRWIDTH  writeback register index.
- i_wbData  in  DATAWIDTH  writeback data.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (i_rst_n), applied on assertion and released synchronously to i_clk.
- Reset values: all registers = 0; state = EMPTY; o_valid = 0; o_op/o_wordA/o_wordB/o_rd = 0; o_ready = 1.
- Register 0 reads as 0 always. Writes to index 0 are discarded, and index 0 is never bypassed.
- Register write: when i_wbValid=1 and i_wbRd!=0, R[i_wbRd] <= i_wbData at the clock edge.
- Read bypass: in the same cycle, if i_wbValid=1, i_wbRd!=0 and i_wbRd equals rs1 (or rs2), the read returns i_wbData, not the stale register.
- Accept: occurs when i_valid && o_ready.
- Latency: an accepted instruction appears on o_* the following cycle when the output slot is free.
- Entry contents: each held entry stores op, rd, rs1, rs2, useImm, wordA and wordB.
- States (o_ready = state != SKID; o_valid = state != EMPTY):
  - EMPTY, on accept: load OUT, go to FULL.
  - FULL:
    - fire only (o_valid && i_ready, no accept): go to EMPTY.
    - accept and fire in the same cycle: reload OUT, stay FULL.
    - accept without fire: load SKID, go to SKID.
    - neither: stay.
  - SKID, with o_ready=0:
    - on fire: OUT <= SKID contents, go to FULL.
    - otherwise: hold.
- Writeback snoop:
  - Every held entry (OUT and SKID) whose rs1 matches a valid non-zero i_wbRd replaces its wordA with i_wbData at that edge.
  - The same applies to rs2/wordB when useImm=0.
  - Entries with useImm=1 never update wordB.
  - Snoop applies in the cycle of a SKID-to-OUT move, using the moving entry's indices.
- o_* are driven only from OUT and are stable while o_valid=1 and i_ready=0, except for snoop updates.
- Upstream rules:
  - While o_ready=0, i_valid is ignored.
  - The downstream side must not require o_valid to be held after a fire.
- Reset asserted mid-operation: all entries drop immediately (o_valid=0), the register file clears, and there is no partial state.
- No arithmetic in this block. Widths pass unchanged, and the immediate is used verbatim (upstream sign-extends).

Decomposition:
- Shared package argon_pkg:
  - opcode localparams (OP_ADD=0 … OP_SLT=7, unique encodings);
  - OPWIDTH/DATAWIDTH/REGADDRWIDTH defaults;
  - state encoding (EMPTY=0, FULL=1, SKID=2).
- One sub-module: argon_regfile. It has 2 combinational read ports with writeback bypass, 1 synchronous write port, and register 0 hardwired to zero.
- The skid/state logic and snoop stay in argon_operand_stage.

Test Plan:
1. Reset then write: wb R3=0x1234, then issue op=ADD rs1=3 rs2=0 useImm=0 rd=5 with i_ready=1 -> next cycle o_valid=1, o_wordA=0x1234, o_wordB=0, o_rd=5.
2. Same-cycle bypass: issue rs1=2 while wbValid rd=2 data=0xBEEF -> o_wordA=0xBEEF. Repeat with wbRd=0 -> o_wordA=0.
3. Backpressure: hold i_ready=0 and issue A then B -> o_ready goes 1→1→0, o_* shows A throughout. Release i_ready -> A fires, then B next cycle, o_ready returns 1, no loss or duplication.
4. Snoop while stalled: A (rs1=4, useImm=1, imm=0x0007) held in OUT, then wb R4=0x00AA -> o_wordA=0x00AA, o_wordB stays 0x0007.
5. Streaming: i_valid=i_ready=1 for 8 cycles with distinct rd -> one output per cycle in order, o_ready constantly 1.
6. Async reset mid-SKID: drop i_rst_n between clock edges -> o_valid=0 and o_ready=1 immediately, and registers read 0 after release.
